lcg_stim_gen: RTL
=================

Name: lcg_stim_gen

Overview:
- Synthesizable upstream stimulus source for the fuzzed `top` DUT.
- Produces `in_flat`-shaped vectors from the team's 32-bit LCG: state = state*32'h41C64E6D + 32'h3039, mod 2^32.
- Fills each vector 32 bits at a time, LSB word first. The final word is truncated to its low bits.
- Hands vectors to the DUT input register over valid/ready. The bit sequence is identical to the simulation stimulus, so emulation runs and sim runs can be diffed vector for vector.

Parameters:
- OUT_W, 139: vector width. Legal range 1..1024.
- NWORDS, (OUT_W+31)/32: derived LCG steps per vector. Do not override.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: synchronous active-low reset.
- start, input, 1: pulse. In IDLE or DONE, loads `seed` and begins a run.
- seed, input, 32: initial LCG state, sampled on an accepted start.
- num_vectors, input, 32: vectors per run, sampled on an accepted start.
- vec_valid, output, 1: vec_data is valid.
- vec_ready, input, 1: consumer accepts the vector.
- vec_data, output, OUT_W: current vector.
- vec_last, output, 1: current vector is the final one of the run.
- vec_count, output, 32: number of vectors accepted in this run.
- busy, output, 1: asserted in GEN or HOLD.
- done, output, 1: run complete, held high.

Behaviour:
- Reset (synchronous, rst_n=0 at a clk edge):
  - State goes to IDLE. lcg_state, word_idx, vec_count, vec_data and the shadow register clear to 0.
  - vec_valid, vec_last, busy, done = 0.
  - Applies in any state and aborts a run in progress. No vector is completed.
- FSM states: IDLE, GEN, HOLD, DONE.
- IDLE/DONE + start=1:
  - lcg_state <= seed; word_idx <= 0; vec_count <= 0; done <= 0.
  - If num_vectors == 0: go to DONE with done=1 on the next cycle. No vector is emitted.
  - Otherwise go to GEN.
- GEN (one LCG step per cycle):
  - nxt = lcg_state*32'h41C64E6D + 32'h3039, truncated to 32 bits.
  - lcg_state <= nxt.
  - shadow[32*word_idx +: w] <= nxt[w-1:0], where w = 32, except on the last word, where w = OUT_W - 32*(NWORDS-1).
  - word_idx increments. After word NWORDS-1: vec_data <= completed shadow, vec_valid <= 1, vec_last <= (vec_count == num_vectors-1), go to HOLD.
- HOLD:
  - vec_data, vec_valid and vec_last stay stable until vec_valid && vec_ready.
  - On handshake: vec_count increments, vec_valid <= 0.
    - If vec_last: go to DONE, done <= 1.
    - Otherwise: word_idx <= 0, go to GEN.
  - LCG state is not advanced while stalled.
- Latency and throughput:
  - The first vec_valid rises NWORDS cycles after the cycle in which start is accepted (5 cycles at OUT_W=139).
  - With vec_ready tied high, throughput is 1 vector per NWORDS+1 cycles.
- start is ignored while busy. DONE holds until start or reset.
- vec_count wraps modulo 2^32. num_vectors = 32'hFFFFFFFF is legal.
- LCG arithmetic is modulo 2^32 throughout. The multiply is a 32x32 product truncated to its low 32 bits.

Optional Feature:
- Macro: LCG_STIM_SIG_EN.
- When defined:
  - Adds output port `sig` (32 bits).
  - On each handshake, sig <= {sig[30:0], sig[31]} ^ fold, where fold is the XOR of all 32-bit words of vec_data, zero-padded at the top.
  - sig clears on reset and on an accepted start.
  - Gives a per-run signature for fast emulation-vs-sim comparison.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Seed and vector content: OUT_W=139, seed=0, num_vectors=1, vec_ready=1, pulse start.
  - vec_valid is high exactly 5 cycles after the start edge.
  - vec_data[31:0]=32'h00003039 and vec_data[63:32]=32'hD3DC167E.
  - vec_last=1. done=1 the cycle after the handshake. vec_count=1.
- Default seed, long run: seed=32'hA1515607, num_vectors=100, vec_ready=1.
  - 100 vectors match the software LCG model bit-exactly, including the 11-bit top word.
  - done asserts at cycle 600 after start (100 vectors x 6 cycles).
- Backpressure: vec_ready low for 7 cycles in HOLD.
  - vec_data and vec_valid stay stable, the next vector is unchanged, and total cycles increase by 7.
- num_vectors=0: start -> done=1 next cycle, vec_valid never asserts, vec_count=0.
- Reset mid-GEN at word_idx=2: all outputs are 0 the next cycle.
  - A fresh start with the same seed reproduces vector 0 exactly.
- Ignored start: start pulsed while busy has no effect.
  - start in DONE with seed=1 clears done and restarts; the first word is 32'h41C67EA6.

Source files
------------

// File: rtl/lcg_stim_gen_if.sv
// lcg_stim_gen_if: valid/ready vector channel from the LCG stimulus source
// to the DUT input register.
//   vec_valid : source -> sink, vec_data/vec_last are valid
//   vec_ready : sink -> source, sink accepts the vector this cycle
//   vec_data  : source -> sink, OUT_W-bit stimulus vector
//   vec_last  : source -> sink, vector is the final one of the run
// Modports: master (stimulus source), slave (consumer).
interface lcg_stim_gen_if #(
  parameter int OUT_W = 139
) ();

  logic             vec_valid;
  logic             vec_ready;
  logic [OUT_W-1:0] vec_data;
  logic             vec_last;

  modport master (
    output vec_valid,
    output vec_data,
    output vec_last,
    input  vec_ready
  );

  modport slave (
    input  vec_valid,
    input  vec_data,
    input  vec_last,
    output vec_ready
  );

endinterface

// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: synthesizable upstream stimulus source for the fuzzed `top`
// DUT. Builds OUT_W-bit vectors from the 32-bit LCG
//   state = state * 32'h41C64E6D + 32'h3039 (mod 2^32)
// one LCG step per cycle, filling 32 bits at a time, LSB word first. The
// final word is truncated to its low bits, so the bit stream matches the
// simulation stimulus exactly and runs can be diffed vector for vector.
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   start       : pulse; in IDLE or DONE loads seed/num_vectors and starts a run
//   seed        : initial LCG state, sampled on an accepted start
//   num_vectors : vectors per run, sampled on an accepted start
//   vec         : lcg_stim_gen_if.master (vec_valid/vec_ready/vec_data/vec_last)
//   vec_count   : number of vectors accepted in this run (wraps mod 2^32)
//   busy        : high while generating or holding a vector
//   done        : run complete, held until start or reset
//   sig         : per-run signature (only with LCG_STIM_SIG_EN defined)
//
// Optional feature macro: LCG_STIM_SIG_EN adds the `sig` output. On each
// handshake sig <= rotl1(sig) ^ fold, where fold is the XOR of all 32-bit
// words of vec_data (top word zero-padded). sig clears on reset and on an
// accepted start.
//
// Parameters:
//   OUT_W  : vector width, 1..1024
//   NWORDS : derived LCG steps per vector; do not override
module lcg_stim_gen #(
  parameter int OUT_W  = 139,
  parameter int NWORDS = (OUT_W + 31) / 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] seed,
  input  logic [31:0] num_vectors,
  lcg_stim_gen_if.master vec,
  output logic [31:0] vec_count,
`ifdef LCG_STIM_SIG_EN
  output logic [31:0] sig,
`endif
  output logic        busy,
  output logic        done
);

  localparam int          WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [31:0] LCG_A  = 32'h41C64E6D;
  localparam logic [31:0] LCG_C  = 32'h00003039;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [31:0]       lcg_state;
  logic [31:0]       lcg_nxt;
  logic [WIDX_W-1:0] word_idx;
  logic [31:0]       num_q;
  logic [OUT_W-1:0]  shadow;
  logic [OUT_W-1:0]  shadow_nxt;
  logic              last_word;
  logic              handshake;
  logic              start_ok;

  // Low 32 bits of the 32x32 product plus increment.
  assign lcg_nxt   = lcg_state * LCG_A + LCG_C;
  assign last_word = (word_idx == WIDX_W'(NWORDS - 1));
  assign handshake = (state == ST_HOLD) && vec.vec_valid && vec.vec_ready;
  assign start_ok  = ((state == ST_IDLE) || (state == ST_DONE)) && start;

  // Shadow with the current word spliced in. Each bit picks its LCG bit
  // when its word index matches; bits past OUT_W on the last word simply
  // do not exist, which gives the required truncation for free.
  for (genvar i = 0; i < OUT_W; i++) begin : g_shadow
    assign shadow_nxt[i] = (word_idx == WIDX_W'(i / 32)) ? lcg_nxt[i % 32]
                                                         : shadow[i];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = (num_vectors == 32'd0) ? ST_DONE : ST_GEN;
        end
      end
      ST_GEN: begin
        if (last_word) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (handshake) begin
          state_nxt = vec.vec_last ? ST_DONE : ST_GEN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy = (state == ST_GEN) || (state == ST_HOLD);
    done = (state == ST_DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lcg_state     <= '0;
      word_idx      <= '0;
      num_q         <= '0;
      shadow        <= '0;
      vec_count     <= '0;
      vec.vec_data  <= '0;
      vec.vec_valid <= 1'b0;
      vec.vec_last  <= 1'b0;
    end else begin
      if (start_ok) begin
        lcg_state <= seed;
        word_idx  <= '0;
        vec_count <= '0;
        num_q     <= num_vectors;
      end

      if (state == ST_GEN) begin
        lcg_state <= lcg_nxt;
        shadow    <= shadow_nxt;
        if (last_word) begin
          vec.vec_data  <= shadow_nxt;
          vec.vec_valid <= 1'b1;
          vec.vec_last  <= (vec_count == num_q - 32'd1);
        end else begin
          word_idx <= word_idx + WIDX_W'(1);
        end
      end

      if (handshake) begin
        vec_count     <= vec_count + 32'd1;
        vec.vec_valid <= 1'b0;
        if (!vec.vec_last) begin
          word_idx <= '0;
        end
      end
    end
  end

`ifdef LCG_STIM_SIG_EN
  localparam int PAD_W = NWORDS * 32;

  logic [PAD_W-1:0]         sig_pad;
  logic [NWORDS:0][31:0]    fold_acc;

  assign sig_pad     = PAD_W'(vec.vec_data);
  assign fold_acc[0] = '0;
  for (genvar k = 0; k < NWORDS; k++) begin : g_fold
    assign fold_acc[k+1] = fold_acc[k] ^ sig_pad[k*32 +: 32];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (start_ok) begin
      sig <= '0;
    end else if (handshake) begin
      sig <= {sig[30:0], sig[31]} ^ fold_acc[NWORDS];
    end
  end
`endif

endmodule
